// File: rtl/imm_pack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imm_pack_pkg                                           |
// | Description : Shared types for the immediate packer and the          |
// |               immediate extender (format selector, counter width).   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package imm_pack_pkg;

    // Immediate format selector, encoded exactly as the in_immsrc port.
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_e;

    // Default width of the saturating error counter.
    localparam int ERRW_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/imm_pack_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imm_pack_if                                            |
// | Description : Request/response handshake bundle of imm_pack.         |
// |   in_valid/in_ready   : request handshake                            |
// |   in_immsrc/in_imm    : format and byte-offset immediate             |
// |   in_base             : template instruction (non-immediate bits)    |
// |   out_valid/out_ready : result handshake                             |
// |   out_instr/out_err   : packed word and out-of-range flag            |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface imm_pack_if;
    import imm_pack_pkg::*;

    logic           in_valid;
    logic           in_ready;
    immsrc_e        in_immsrc;
    logic [31:0]    in_imm;
    logic [31:0]    in_base;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_instr;
    logic           out_err;

    // Requester / result consumer side.
    modport master (
        output in_valid, in_immsrc, in_imm, in_base, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    // Packer side.
    modport slave (
        input  in_valid, in_immsrc, in_imm, in_base, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface
`default_nettype wire

// File: rtl/imm_pack_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imm_pack_enc                                           |
// | Description : Combinational immediate packer and range checker.      |
// |               Scatters the immediate into the instruction fields of  |
// |               the selected format; all other bits come from base.    |
// |   immsrc_i : format select     imm_i  : immediate to encode          |
// |   base_i   : template word     instr_o: packed word                  |
// |   err_o    : immediate not representable (word is then truncated)    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module imm_pack_enc
    import imm_pack_pkg::*;
(
    input  immsrc_e        immsrc_i,
    input  logic [31:0]    imm_i,
    input  logic [31:0]    base_i,
    output logic [31:0]    instr_o,
    output logic           err_o
);

    // A value fits in N signed bits when bits [31:N-1] are all copies
    // of the sign bit.
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    assign w_fit12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign w_fit13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign w_fit21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    always_comb begin
        instr_o = base_i;
        err_o   = 1'b0;
        case (immsrc_i)
            IMM_I: begin
                instr_o = {imm_i[11:0], base_i[19:0]};
                err_o   = ~w_fit12;
            end
            IMM_S: begin
                instr_o = {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]};
                err_o   = ~w_fit12;
            end
            // Branch and jump offsets are halfword aligned: bit 0 is not
            // encodable, so an odd offset is an error.
            IMM_B: begin
                instr_o = {imm_i[12], imm_i[10:5], base_i[24:12],
                           imm_i[4:1], imm_i[11], base_i[6:0]};
                err_o   = ~w_fit13 | imm_i[0];
            end
            IMM_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                           base_i[11:0]};
                err_o   = ~w_fit21 | imm_i[0];
            end
            default: begin
                instr_o = base_i;
                err_o   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imm_pack                                               |
// | Description : Immediate packer with one registered output stage and  |
// |               a saturating count of out-of-range requests.           |
// |   clk       : rising-edge clock                                      |
// |   reset     : synchronous active-high reset                          |
// |   bus       : request/result handshake bundle (slave side)           |
// |   err_count : saturating count of accepted requests with error       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int ERRW = ERRW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    imm_pack_if.slave         bus,
    output logic [ERRW-1:0]   err_count
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q,   err_d;
    logic [ERRW-1:0]  cnt_q,   cnt_d;

    logic [31:0]      w_instr;
    logic             w_err;
    logic             w_accept;
    logic             w_drain;

    imm_pack_enc u_enc (
        .immsrc_i (bus.in_immsrc),
        .imm_i    (bus.in_imm),
        .base_i   (bus.in_base),
        .instr_o  (w_instr),
        .err_o    (w_err)
    );

    // The single stage can take a new request whenever it is empty or
    // its current contents leave in the same cycle.
    assign bus.in_ready = (state_q == S_EMPTY) || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_drain      = (state_q == S_FULL) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_EMPTY: if (w_accept)              state_d = S_FULL;
            S_FULL:  if (w_drain && !w_accept)  state_d = S_EMPTY;
            default:                            state_d = S_EMPTY;
        endcase

        if (w_accept) begin
            instr_d = w_instr;
            err_d   = w_err;
            if (w_err && (cnt_q != {ERRW{1'b1}})) begin
                cnt_d = cnt_q + ERRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = (state_q == S_FULL);
    assign bus.out_instr = instr_q;
    assign bus.out_err   = err_q;
    assign err_count     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_imm_pack                                            |
// | Description : Self-checking bench for imm_pack. Expected results are |
// |               queued at request acceptance; a monitor pops and       |
// |               checks them via a decoding extender and range rules.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_imm_pack;
    import imm_pack_pkg::*;

    // Narrow counter so saturation is reachable in a short run.
    localparam int ERRW = 4;
    localparam int CMAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [ERRW-1:0] err_count;

    imm_pack_if bus ();

    imm_pack #(.ERRW(ERRW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic        err;
        logic        has_exact;
        logic [31:0] exact;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    logic mv = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Signed width of the offset field for each format.
    function automatic int fw(input logic [1:0] src);
        case (src)
            2'd0, 2'd1: return 12;
            2'd2:       return 13;
            default:    return 21;
        endcase
    endfunction

    function automatic logic model_err(input logic [1:0] src, input logic [31:0] imm);
        longint s, lo, hi;
        s  = longint'($signed(imm));
        lo = -(longint'(1) << (fw(src) - 1));
        hi = (longint'(1) << (fw(src) - 1)) - 1;
        return (s < lo) || (s > hi) || (src[1] && imm[0]);
    endfunction

    // Value the decoder must recover: low field bits sign-extended,
    // with bit 0 dropped for the halfword-aligned formats.
    function automatic logic [31:0] model_trunc(input logic [1:0] src, input logic [31:0] imm);
        logic [31:0] mask, v;
        mask = (32'h1 << fw(src)) - 32'h1;
        v    = imm & mask;
        if (((v >> (fw(src) - 1)) & 32'h1) != 0) v = v | ~mask;
        if (src[1]) v[0] = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] base_mask(input logic [1:0] src);
        case (src)
            2'd0:       return 32'h000F_FFFF;
            2'd1, 2'd2: return 32'h01FF_F07F;
            default:    return 32'h0000_0FFF;
        endcase
    endfunction

    // Reference immediate extender (instruction decoder side).
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] src);
        case (src)
            2'd0:    return {{20{w[31]}}, w[31:20]};
            2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input logic [1:0] src, input logic legal);
        logic [31:0] r;
        int          pick;
        if (!legal) return $urandom;
        pick = $urandom_range(0, 15);
        if (pick == 0)      r = (32'h1 << (fw(src) - 1)) - 32'h1;
        else if (pick == 1) r = 32'hFFFF_FFFF << (fw(src) - 1);
        else                r = model_trunc(src, $urandom);
        if (src[1]) r[0] = 1'b0;
        return r;
    endfunction

    // One clock cycle of stimulus; checks state visible after the edge.
    task automatic cyc(input logic v, input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] base, input logic ordy,
                       input logic hx, input logic [31:0] ex);
        logic acc, drain;
        exp_t e;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.in_valid   = v;
        bus.in_immsrc  = immsrc_e'(src);
        bus.in_imm     = imm;
        bus.in_base    = base;
        bus.out_ready  = ordy;
        @(negedge clk);
        check("out_valid", 32'(bus.out_valid), 32'(mv));
        check("in_ready", 32'(bus.in_ready), 32'(!mv || ordy));
        check("err_count", 32'(err_count), 32'(exp_cnt));
        acc   = v && (!mv || ordy);
        drain = mv && ordy;
        if (acc) begin
            e.src = src; e.imm = imm; e.base = base;
            e.err = model_err(src, imm);
            e.has_exact = hx; e.exact = ex;
            sb.push_back(e);
            if (e.err && exp_cnt < CMAX) exp_cnt++;
        end
        mv = acc ? 1'b1 : (drain ? 1'b0 : mv);
    endtask

    task automatic rst_cyc();
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_immsrc = IMM_I;
        bus.in_imm    = 32'hFFFF_F000;
        bus.in_base   = $urandom;
        bus.out_ready = 1'b0;
        @(negedge clk);
        sb.delete();
        mv      = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic rnd_req(input logic ordy);
        logic [1:0] s;
        s = 2'($urandom_range(0, 3));
        cyc(1'b1, s, gen_imm(s, $urandom_range(0, 9) != 0), $urandom, ordy, 1'b0, 32'h0);
    endtask

    // Result monitor: every transfer is matched against the queue head.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", bus.out_instr, 32'hx);
            end else begin
                e_mon = sb.pop_front();
                check("round_trip", extend(bus.out_instr, e_mon.src), model_trunc(e_mon.src, e_mon.imm));
                check("base_bits", bus.out_instr & base_mask(e_mon.src), e_mon.base & base_mask(e_mon.src));
                check("out_err", 32'(bus.out_err), 32'(e_mon.err));
                if (e_mon.has_exact) check("exact_instr", bus.out_instr, e_mon.exact);
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_immsrc = IMM_I;
        bus.in_imm    = 32'h0;
        bus.in_base   = 32'h0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_err", 32'(bus.out_err), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Known-answer vectors.
        cyc(1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 1, 1, 32'hFFF0_0013);
        cyc(1, 2'd1, 32'h0000_0008, 32'h0011_2023, 1, 1, 32'h0011_2423);
        cyc(1, 2'd2, 32'hFFFF_FFFC, 32'h0000_0063, 1, 1, 32'hFE00_0EE3);
        cyc(1, 2'd3, 32'h0000_0800, 32'h0000_00EF, 1, 1, 32'h0010_00EF);
        cyc(1, 2'd3, 32'h0000_0801, 32'h0000_00EF, 1, 0, 32'h0);
        cyc(1, 2'd0, 32'h0000_0800, 32'h0000_0013, 1, 1, 32'h8000_0013);
        cyc(0, 2'd0, 32'h0000_0800, 32'h0000_0013, 1, 0, 32'h0);

        // Range boundaries on both sides of each format.
        cyc(1, 2'd0, 32'h0000_07FF, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd0, 32'hFFFF_F800, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd1, 32'hFFFF_F7FF, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd2, 32'h0000_0FFE, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd2, 32'hFFFF_F000, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd2, 32'h0000_1000, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd2, 32'h0000_0001, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd3, 32'h000F_FFFE, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd3, 32'hFFF0_0000, $urandom, 1, 0, 32'h0);
        cyc(1, 2'd3, 32'h0010_0000, $urandom, 1, 0, 32'h0);

        // Counter saturation.
        for (int i = 0; i < 20; i++) cyc(1, 2'd1, 32'h0001_0000, $urandom, 1, 0, 32'h0);

        // Back-pressure: hold, then back-to-back acceptance.
        rnd_req(1'b1);
        for (int i = 0; i < 5; i++) rnd_req(1'b0);
        for (int i = 0; i < 6; i++) rnd_req(1'b1);

        // Reset with a held result and a pending request.
        rnd_req(1'b0);
        rst_cyc();
        rnd_req(1'b1);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) rst_cyc();
            if ($urandom_range(0, 7) == 0)
                cyc(0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3) != 0, 0, 32'h0);
            else
                rnd_req($urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 4; i++) cyc(0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
